// File: rtl/team_01_btn_pkg.sv
// Shared constants and types for the team_01 button conditioner.
// Auto-repeat is compiled in only when BTN_AUTOREPEAT_EN is defined.
package team_01_btn_pkg;

    localparam int N_BTN_DEFAULT           = 7;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 50;
    localparam int REPEAT_DELAY_DEFAULT    = 12_500_000;
    localparam int REPEAT_PERIOD_DEFAULT   = 2_500_000;
    localparam logic [N_BTN_DEFAULT-1:0] REPEAT_MASK_DEFAULT = 7'b0001111;

    // Channel wired to mprj_io[11], the AI start button
    localparam int BTN_AI_START = 6;

    typedef enum logic {
        REP_FIRST    = 1'b0,
        REP_PERIODIC = 1'b1
    } rep_phase_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/team_01_btn_debounce.sv
// One button channel: 2-flop synchronizer, debounce counter, registered pulses.
// Optional auto-repeat on press when BTN_AUTOREPEAT_EN is defined.
module team_01_btn_debounce
    import team_01_btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT,
    parameter bit REPEAT_ENABLE = 1'b0
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             s1;
    logic             s2;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             press_q;
    logic             release_q;
    logic             accept;
    logic             repeat_pulse;

    assign accept = (s2 != stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_i;
            s2 <= s1;
        end
    end

    // Dropping en discards debounce progress, so a held button re-debounces as a new press
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            stable    <= 1'b0;
            cnt       <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= repeat_pulse;
            release_q <= 1'b0;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable    <= s2;
                cnt       <= '0;
                press_q   <= s2;
                release_q <= !s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    generate
        if (REPEAT_ENABLE) begin : g_repeat
            localparam int REP_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
            localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

            logic [REP_W-1:0] rep_cnt;
            logic [REP_W-1:0] rep_limit;
            rep_phase_e       rep_phase;

            assign rep_limit = (rep_phase == REP_PERIODIC) ? REP_W'(REPEAT_PERIOD - 1)
                                                           : REP_W'(REPEAT_DELAY - 1);

            // Counts only while held; the release-accept edge must not emit a repeat
            always_ff @(posedge clk) begin
                if (rst || !en || !stable || accept) begin
                    rep_cnt   <= '0;
                    rep_phase <= REP_FIRST;
                end else if (rep_cnt == rep_limit) begin
                    rep_cnt   <= '0;
                    rep_phase <= REP_PERIODIC;
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end

            assign repeat_pulse = en && stable && !accept && (rep_cnt == rep_limit);
        end else begin : g_no_repeat
            assign repeat_pulse = 1'b0;
        end
    endgenerate
`else
    assign repeat_pulse = 1'b0;
`endif

    assign level_o   = stable;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/team_01_btn_conditioner.sv
// Conditions the team_01 GPIO buttons into clean levels and press/release pulses.
// Define BTN_AUTOREPEAT_EN to add auto-repeat on channels selected by REPEAT_MASK.
module team_01_btn_conditioner
    import team_01_btn_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int                 REPEAT_DELAY  = REPEAT_DELAY_DEFAULT,
    parameter int                 REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT,
    parameter logic [N_BTN-1:0]   REPEAT_MASK   = REPEAT_MASK_DEFAULT
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] btn_press_o,
    output logic [N_BTN-1:0] btn_release_o
);

    generate
        for (genvar i = 0; i < N_BTN; i++) begin : g_chan
            team_01_btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
                ,
                .REPEAT_DELAY (REPEAT_DELAY),
                .REPEAT_PERIOD(REPEAT_PERIOD),
                .REPEAT_ENABLE(REPEAT_MASK[i])
`endif
            ) u_chan (
                .clk      (clk),
                .rst      (rst),
                .en       (en),
                .btn_i    (btn_i[i]),
                .level_o  (btn_level_o[i]),
                .press_o  (btn_press_o[i]),
                .release_o(btn_release_o[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_team_01_btn_conditioner.sv
// Directed bench for team_01_btn_conditioner with a pulse scoreboard.
// Defining BTN_AUTOREPEAT_EN adds a second instance exercising auto-repeat.
module tb_team_01_btn_conditioner;
    import team_01_btn_pkg::*;

    localparam int DEB  = 50;
    localparam int DREP = 10;
    localparam int RDLY = 200;
    localparam int RPER = 50;

    typedef struct {
        int         cyc;
        logic [6:0] press;
        logic [6:0] rel;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [6:0] btn_i;
    logic [6:0] btn_level_o;
    logic [6:0] btn_press_o;
    logic [6:0] btn_release_o;

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t sb[$];

    team_01_btn_conditioner #(
        .N_BTN          (7),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .btn_i        (btn_i),
        .btn_level_o  (btn_level_o),
        .btn_press_o  (btn_press_o),
        .btn_release_o(btn_release_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Expected pulse lands DEB+2 edges after the drive point
    task automatic applyStimulus(input logic [6:0] value, input logic [6:0] exp_press,
                                 input logic [6:0] exp_rel);
        ev_t e;
        btn_i = value;
        if ((exp_press | exp_rel) != 7'd0) begin
            e.cyc   = cyc + DEB + 2;
            e.press = exp_press;
            e.rel   = exp_rel;
            sb.push_back(e);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if ((btn_press_o | btn_release_o) != 7'd0) begin
            checkOutput("press_and_release", {25'd0, btn_press_o & btn_release_o}, 32'd0);
            if (sb.size() == 0) begin
                checkOutput("unexpected_pulse", {18'd0, btn_press_o, btn_release_o}, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("event_cycle", cyc, e.cyc);
                checkOutput("event_press", {25'd0, btn_press_o}, {25'd0, e.press});
                checkOutput("event_release", {25'd0, btn_release_o}, {25'd0, e.rel});
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    logic [6:0] rbtn;
    logic [6:0] rlevel;
    logic [6:0] rpress;
    logic [6:0] rrelease;
    ev_t        sb_rep[$];

    team_01_btn_conditioner #(
        .N_BTN          (7),
        .DEBOUNCE_CYCLES(DREP),
        .REPEAT_DELAY   (RDLY),
        .REPEAT_PERIOD  (RPER),
        .REPEAT_MASK    (7'b0001111)
    ) dut_rep (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .btn_i        (rbtn),
        .btn_level_o  (rlevel),
        .btn_press_o  (rpress),
        .btn_release_o(rrelease)
    );

    task automatic pushRep(input int at, input logic [6:0] p, input logic [6:0] r);
        ev_t e;
        e.cyc   = at;
        e.press = p;
        e.rel   = r;
        sb_rep.push_back(e);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if ((rpress | rrelease) != 7'd0) begin
            if (sb_rep.size() == 0) begin
                checkOutput("rep_unexpected_pulse", {18'd0, rpress, rrelease}, 32'd0);
            end else begin
                e = sb_rep.pop_front();
                checkOutput("rep_event_cycle", cyc, e.cyc);
                checkOutput("rep_event_press", {25'd0, rpress}, {25'd0, e.press});
                checkOutput("rep_event_release", {25'd0, rrelease}, {25'd0, e.rel});
            end
        end
    end
`endif

    initial begin
        ev_t e;
        int  k;
        rst   = 1'b1;
        en    = 1'b1;
        btn_i = 7'd0;
`ifdef BTN_AUTOREPEAT_EN
        rbtn  = 7'd0;
`endif
        waitCycles(3);
        checkOutput("reset_level", {25'd0, btn_level_o}, 32'd0);
        checkOutput("reset_press", {25'd0, btn_press_o}, 32'd0);
        checkOutput("reset_release", {25'd0, btn_release_o}, 32'd0);
        rst = 1'b0;
        waitCycles(5);

        // AI start button: held 100 cycles, exact accept boundaries on both edges
        applyStimulus(7'h40, 7'h40, 7'h00);
        waitCycles(DEB + 1);
        checkOutput("ai_level_before_accept", {25'd0, btn_level_o}, 32'd0);
        waitCycles(1);
        checkOutput("ai_level_after_accept", {31'd0, btn_level_o[BTN_AI_START]}, 32'd1);
        waitCycles(100 - DEB - 2);
        applyStimulus(7'h00, 7'h00, 7'h40);
        waitCycles(DEB + 1);
        checkOutput("ai_level_before_release", {25'd0, btn_level_o}, 32'h40);
        waitCycles(1);
        checkOutput("ai_level_after_release", {25'd0, btn_level_o}, 32'd0);
        waitCycles(5);

        // Glitches shorter than DEB cycles are discarded
        applyStimulus(7'h01, 7'h00, 7'h00);
        waitCycles(30);
        applyStimulus(7'h00, 7'h00, 7'h00);
        waitCycles(60);
        checkOutput("glitch30_level", {25'd0, btn_level_o}, 32'd0);
        applyStimulus(7'h01, 7'h00, 7'h00);
        waitCycles(DEB - 1);
        applyStimulus(7'h00, 7'h00, 7'h00);
        waitCycles(60);
        checkOutput("glitch49_level", {25'd0, btn_level_o}, 32'd0);

        // Simultaneous presses on two channels
        applyStimulus(7'h12, 7'h12, 7'h00);
        waitCycles(60);
        checkOutput("dual_level", {25'd0, btn_level_o}, 32'h12);
        applyStimulus(7'h00, 7'h00, 7'h12);
        waitCycles(60);
        checkOutput("dual_released", {25'd0, btn_level_o}, 32'd0);

        // en drops mid-debounce (cnt=25); press lands DEB cycles after en returns
        applyStimulus(7'h04, 7'h00, 7'h00);
        waitCycles(27);
        en = 1'b0;
        waitCycles(10);
        checkOutput("en_gap_level", {25'd0, btn_level_o}, 32'd0);
        en      = 1'b1;
        e.cyc   = cyc + DEB;
        e.press = 7'h04;
        e.rel   = 7'h00;
        sb.push_back(e);
        waitCycles(DEB - 1);
        checkOutput("en_level_before_accept", {25'd0, btn_level_o}, 32'd0);
        waitCycles(1);
        checkOutput("en_level_after_accept", {25'd0, btn_level_o}, 32'h04);
        applyStimulus(7'h00, 7'h00, 7'h04);
        waitCycles(60);

        // One-cycle reset while held: level drops silently, press re-debounced
        applyStimulus(7'h08, 7'h08, 7'h00);
        waitCycles(60);
        checkOutput("rst_held_level", {25'd0, btn_level_o}, 32'h08);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("rst_level_cleared", {25'd0, btn_level_o}, 32'd0);
        rst = 1'b0;
        applyStimulus(7'h08, 7'h08, 7'h00);
        waitCycles(60);
        checkOutput("rst_level_restored", {25'd0, btn_level_o}, 32'h08);
        applyStimulus(7'h00, 7'h00, 7'h08);
        waitCycles(60);

`ifdef BTN_AUTOREPEAT_EN
        // Channel 0 repeats, channel 5 is outside the mask
        k    = cyc;
        rbtn = 7'h21;
        pushRep(k + DREP + 2, 7'h21, 7'h00);
        for (int j = 0; j < 4; j++) pushRep(k + DREP + 2 + RDLY + j * RPER, 7'h01, 7'h00);
        waitCycles(400);
        k    = cyc;
        rbtn = 7'h00;
        pushRep(k + DREP + 2, 7'h00, 7'h21);
        waitCycles(30);
        checkOutput("rep_level_released", {25'd0, rlevel}, 32'd0);
        checkOutput("rep_sb_empty", sb_rep.size(), 32'd0);
`endif

        waitCycles(5);
        checkOutput("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
